flash_writer: RTL and testbench

Programs the user region of the SPI flash from the CPU side: sector erase and 32-bit word program, each followed by status polling until the write completes. It pairs with the boot/CPU flash reader on the same SPI pins, and the top level arbitrates pin ownership through a request/grant handshake. CPU firmware uses it to store save data and updated assets at or above 0x100000 without touching the bitstream area.

---
 rtl/flash_writer_pkg.sv | 31 +++
 rtl/flash_writer_spi_shifter.sv | 77 +++++++
 rtl/flash_writer.sv | 224 ++++++++++++++++++++++
 tb/tb_flash_writer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_writer_pkg.sv
// Shared constants for the SPI flash writer: opcodes, default user-region base,
// FSM state encoding and the program-frame packing helper.
package flash_writer_pkg;

    localparam logic [7:0] OpWren       = 8'h06;
    localparam logic [7:0] OpProgram    = 8'h02;
    localparam logic [7:0] OpErase      = 8'h20;
    localparam logic [7:0] OpReadStatus = 8'h05;

    // Lowest writable byte; everything below belongs to the bitstream.
    localparam logic [23:0] DefUserBase     = 24'h100000;
    localparam int unsigned DefCsIdleCycles = 4;
    localparam logic [23:0] DefPollLimit    = 24'hFFFFFF;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWren,
        StGap,
        StWrite,
        StPoll,
        StFinish
    } state_e;

    // Opcode, big-endian address, then data bytes lowest address first.
    function automatic logic [63:0] program_frame(input logic [23:0] addr,
                                                  input logic [31:0] data);
        return {OpProgram, addr, data[7:0], data[15:8], data[23:16], data[31:24]};
    endfunction

endpackage

// File: rtl/flash_writer_spi_shifter.sv
// Mode-0 SPI frame engine (module spi_flash_shifter): shifts out up to 64 bits
// MSB-first at clk/2, captures the last 8 MISO bits and flags the final frame cycle.
module spi_flash_shifter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [63:0] tx_data_i,
    input  logic [6:0]  tx_bits_i,
    input  logic        miso_i,
    output logic        shift_done_o,
    output logic [7:0]  rx_data_o,
    output logic        sck_o,
    output logic        csn_o,
    output logic        mosi_o
);

    logic        active_q;
    logic        sck_q;
    logic        csn_q;
    logic        mosi_q;
    logic [6:0]  cnt_q;
    logic [63:0] shreg_q;
    logic [7:0]  rx_q;

    // Frame sequencing: csn low, then alternate sck low/high per bit, then close.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            csn_q    <= 1'b1;
            mosi_q   <= 1'b0;
            cnt_q    <= '0;
            shreg_q  <= '0;
            rx_q     <= '0;
        end else if (abort_i) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            csn_q    <= 1'b1;
            mosi_q   <= 1'b0;
        end else if (start_i) begin
            active_q <= 1'b1;
            sck_q    <= 1'b0;
            csn_q    <= 1'b0;
            shreg_q  <= tx_data_i;
            mosi_q   <= tx_data_i[63];
            cnt_q    <= tx_bits_i;
        end else if (active_q) begin
            if (!sck_q) begin
                if (cnt_q != 7'd0) begin
                    // Rising edge: flash data is sampled here.
                    sck_q <= 1'b1;
                    rx_q  <= {rx_q[6:0], miso_i};
                    cnt_q <= cnt_q - 7'd1;
                end else begin
                    active_q <= 1'b0;
                    csn_q    <= 1'b1;
                    mosi_q   <= 1'b0;
                end
            end else begin
                sck_q <= 1'b0;
                if (cnt_q != 7'd0) begin
                    shreg_q <= shreg_q << 1;
                    mosi_q  <= shreg_q[62];
                end
            end
        end
    end

    // Last csn-low cycle: every bit clocked and sck back low.
    assign shift_done_o = active_q && !sck_q && (cnt_q == 7'd0);
    assign rx_data_o    = rx_q;
    assign sck_o        = sck_q;
    assign csn_o        = csn_q;
    assign mosi_o       = mosi_q;

endmodule

// File: rtl/flash_writer.sv
// CPU-side SPI flash writer: word program and (with FLASH_WRITER_ERASE_EN defined)
// 4 KB sector erase in the user region, with WREN, status polling and SPI pin
// arbitration via spi_request/spi_grant.
module flash_writer
    import flash_writer_pkg::*;
#(
    parameter logic [23:0] UserBase     = DefUserBase,
    parameter int unsigned CsIdleCycles = DefCsIdleCycles,
    parameter logic [23:0] PollLimit    = DefPollLimit
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_erase_i,
    input  logic [23:0] req_address_i,
    input  logic [31:0] req_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        spi_request_o,
    input  logic        spi_grant_i,
    output logic        flash_sck_o,
    output logic        flash_csn_o,
    output logic        flash_mosi_o,
    input  logic        flash_miso_i
);

    localparam logic [7:0] GapLoad = 8'(CsIdleCycles - 1);

    state_e      state_q;
    logic [23:0] addr_q;
    logic [31:0] data_q;
    logic        next_poll_q;
    logic [7:0]  gap_cnt_q;
    logic [23:0] poll_cnt_q;
    logic        done_q;
    logic        error_q;
    logic        spi_request_q;

    logic        req_bad;
    logic        grant_lost;
    logic        erase_sel;
    logic        sh_start;
    logic        sh_done;
    logic [63:0] sh_tx;
    logic [6:0]  sh_bits;
    logic [7:0]  sh_rx;
    logic        unused_rx;

`ifdef FLASH_WRITER_ERASE_EN
    logic erase_q;

    // Remember which write command this request needs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            erase_q <= 1'b0;
        end else if (state_q == StIdle && req_valid_i) begin
            erase_q <= req_erase_i;
        end
    end

    assign erase_sel = erase_q;
`else
    assign erase_sel = 1'b0;
`endif

    // Requests that must never reach the flash.
    always_comb begin
        req_bad = (req_address_i < UserBase);
`ifdef FLASH_WRITER_ERASE_EN
        if (!req_erase_i && req_address_i[1:0] != 2'b00) begin
            req_bad = 1'b1;
        end
`else
        if (req_erase_i || req_address_i[1:0] != 2'b00) begin
            req_bad = 1'b1;
        end
`endif
    end

    assign grant_lost = !spi_grant_i &&
                        (state_q == StWren || state_q == StGap ||
                         state_q == StWrite || state_q == StPoll);

    // Frame launch: WREN on grant, write or status read when the gap expires.
    always_comb begin
        sh_start = 1'b0;
        sh_tx    = '0;
        sh_bits  = '0;
        if (state_q == StReq && spi_grant_i) begin
            sh_start = 1'b1;
            sh_tx    = {OpWren, 56'h0};
            sh_bits  = 7'd8;
        end else if (state_q == StGap && !grant_lost && gap_cnt_q == 8'd0) begin
            sh_start = 1'b1;
            if (next_poll_q) begin
                sh_tx   = {OpReadStatus, 56'h0};
                sh_bits = 7'd16;
            end else if (erase_sel) begin
                sh_tx   = {OpErase, addr_q, 32'h0};
                sh_bits = 7'd32;
            end else begin
                sh_tx   = program_frame(addr_q, data_q);
                sh_bits = 7'd64;
            end
        end
    end

    // Main sequencer: accept/check, WREN, write, poll, finish.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            data_q        <= '0;
            next_poll_q   <= 1'b0;
            gap_cnt_q     <= '0;
            poll_cnt_q    <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            spi_request_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (grant_lost) begin
                state_q       <= StFinish;
                done_q        <= 1'b1;
                error_q       <= 1'b1;
                spi_request_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (req_valid_i) begin
                            if (req_bad) begin
                                state_q <= StFinish;
                                done_q  <= 1'b1;
                                error_q <= 1'b1;
                            end else begin
                                state_q       <= StReq;
                                spi_request_q <= 1'b1;
                                addr_q        <= req_address_i;
                                data_q        <= req_data_i;
                                poll_cnt_q    <= '0;
                            end
                        end
                    end
                    StReq: begin
                        if (spi_grant_i) state_q <= StWren;
                    end
                    StWren: begin
                        if (sh_done) begin
                            state_q     <= StGap;
                            next_poll_q <= 1'b0;
                            gap_cnt_q   <= GapLoad;
                        end
                    end
                    StGap: begin
                        if (gap_cnt_q == 8'd0) begin
                            state_q <= next_poll_q ? StPoll : StWrite;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - 8'd1;
                        end
                    end
                    StWrite: begin
                        if (sh_done) begin
                            state_q     <= StGap;
                            next_poll_q <= 1'b1;
                            gap_cnt_q   <= GapLoad;
                        end
                    end
                    StPoll: begin
                        if (sh_done) begin
                            if (!sh_rx[0]) begin
                                state_q       <= StFinish;
                                done_q        <= 1'b1;
                                spi_request_q <= 1'b0;
                            end else if (poll_cnt_q == PollLimit - 24'd1) begin
                                state_q       <= StFinish;
                                done_q        <= 1'b1;
                                error_q       <= 1'b1;
                                spi_request_q <= 1'b0;
                            end else begin
                                poll_cnt_q <= poll_cnt_q + 24'd1;
                                state_q    <= StGap;
                                gap_cnt_q  <= GapLoad;
                            end
                        end
                    end
                    StFinish: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    spi_flash_shifter u_shifter (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (sh_start),
        .abort_i      (grant_lost),
        .tx_data_i    (sh_tx),
        .tx_bits_i    (sh_bits),
        .miso_i       (flash_miso_i),
        .shift_done_o (sh_done),
        .rx_data_o    (sh_rx),
        .sck_o        (flash_sck_o),
        .csn_o        (flash_csn_o),
        .mosi_o       (flash_mosi_o)
    );

    // Only WIP drives the sequencer; the rest of the status byte is ignored.
    assign unused_rx = ^sh_rx[7:1];

    assign req_ready_o   = (state_q == StIdle);
    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign spi_request_o = spi_request_q;

endmodule

// File: tb/tb_flash_writer.sv
// Directed bench for flash_writer with a small SPI flash model on the pins.
module tb_flash_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_erase;
    logic [23:0] req_address;
    logic [31:0] req_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        spi_request;
    logic        spi_grant;
    logic        flash_sck;
    logic        flash_csn;
    logic        flash_mosi;
    logic        flash_miso;
    logic        grant_en;

    int n_checks = 0;
    int n_errors = 0;

    // Flash model / bus monitor state.
    logic [63:0] mon_fr;
    int          mon_nbits;
    int          mon_low;
    logic [7:0]  mon_opc;
    logic        mon_wip;
    logic        prev_csn = 1'b1;
    logic        prev_sck = 1'b0;
    logic [63:0] fr_data[$];
    int          fr_bits[$];
    int          fr_low[$];
    logic        wip_q[$];
    logic        wip_default;
    logic        req_seen;
    int          cyc = 0;
    int          req_cyc;
    int          done_cyc;

    logic [63:0] exp_data[$];
    int          exp_bits[$];

    flash_writer #(
        .PollLimit (24'd3)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_erase_i   (req_erase),
        .req_address_i (req_address),
        .req_data_i    (req_data),
        .busy_o        (busy),
        .done_o        (done),
        .error_o       (error),
        .spi_request_o (spi_request),
        .spi_grant_i   (spi_grant),
        .flash_sck_o   (flash_sck),
        .flash_csn_o   (flash_csn),
        .flash_mosi_o  (flash_mosi),
        .flash_miso_i  (flash_miso)
    );

    always #5 clk = ~clk;

    assign spi_grant = spi_request & grant_en;

    // Sample the pins mid-cycle: log frames, drive the status byte back.
    always @(negedge clk) begin
        cyc++;
        if (spi_request) begin
            req_seen = 1'b1;
            if (req_cyc < 0) req_cyc = cyc;
        end
        if (done && done_cyc < 0) done_cyc = cyc;
        if (!flash_csn) begin
            if (prev_csn) begin
                mon_fr    = '0;
                mon_nbits = 0;
                mon_low   = 0;
                mon_opc   = '0;
            end
            mon_low++;
            if (flash_sck && !prev_sck) begin
                mon_fr = {mon_fr[62:0], flash_mosi};
                mon_nbits++;
                if (mon_nbits == 8) begin
                    mon_opc = mon_fr[7:0];
                    if (mon_opc == 8'h05) begin
                        mon_wip = (wip_q.size() > 0) ? wip_q.pop_front() : wip_default;
                    end
                end
            end
            // Status byte is 0000000<WIP>, so only the final bit can be 1.
            flash_miso = (!flash_sck && mon_nbits == 15 && mon_opc == 8'h05) ? mon_wip : 1'b0;
        end else begin
            flash_miso = 1'b0;
            if (!prev_csn) begin
                fr_data.push_back(mon_fr);
                fr_bits.push_back(mon_nbits);
                fr_low.push_back(mon_low);
            end
        end
        prev_csn = flash_csn;
        prev_sck = flash_sck;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        fr_data.delete();
        fr_bits.delete();
        fr_low.delete();
        exp_data.delete();
        exp_bits.delete();
        wip_q.delete();
        req_seen = 1'b0;
        req_cyc  = -1;
        done_cyc = -1;
    endtask

    task automatic expect_frame(input logic [63:0] d, input int b);
        exp_data.push_back(d);
        exp_bits.push_back(b);
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_nframes"}, 64'(fr_data.size()), 64'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < fr_data.size(); i++) begin
            check($sformatf("%s_f%0d_data", tag, i), fr_data[i], exp_data[i]);
            check($sformatf("%s_f%0d_bits", tag, i), 64'(fr_bits[i]), 64'(exp_bits[i]));
            check($sformatf("%s_f%0d_csn_low", tag, i), 64'(fr_low[i]),
                  64'(2 * exp_bits[i] + 1));
        end
    endtask

    // Present one request at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic e, input logic [23:0] a, input logic [31:0] d);
        check("send_ready", req_ready, 1'b1);
        req_valid   = 1'b1;
        req_erase   = e;
        req_address = a;
        req_data    = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        check({tag, "_done_seen"}, done, 1'b1);
    endtask

    task automatic reject(input string tag, input logic e, input logic [23:0] a);
        clear_log();
        send(e, a, 32'h5555AAAA);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_error"}, error, 1'b1);
        check({tag, "_csn"}, flash_csn, 1'b1);
        @(negedge clk);
        check({tag, "_ready_back"}, req_ready, 1'b1);
        check({tag, "_done_pulse"}, done, 1'b0);
        repeat (3) @(negedge clk);
        check({tag, "_no_request"}, req_seen, 1'b0);
        check({tag, "_no_frames"}, 64'(fr_data.size()), 64'd0);
    endtask

    initial begin
        rst_n       = 1'b1;
        req_valid   = 1'b0;
        req_erase   = 1'b0;
        req_address = '0;
        req_data    = '0;
        grant_en    = 1'b1;
        wip_default = 1'b0;
        mon_wip     = 1'b0;
        flash_miso  = 1'b0;
        clear_log();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_spi_request", spi_request, 1'b0);
        check("rst_csn", flash_csn, 1'b1);
        check("rst_sck", flash_sck, 1'b0);
        check("rst_mosi", flash_mosi, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Program with two busy polls, then back-to-back low-address reject.
        clear_log();
        wip_q.push_back(1'b1);
        wip_q.push_back(1'b1);
        wip_q.push_back(1'b0);
        send(1'b0, 24'h100004, 32'hDDCCBBAA);
        check("p1_busy", busy, 1'b1);
        check("p1_done_early", done, 1'b0);
        wait_done("p1");
        check("p1_error", error, 1'b0);
        check("p1_req_dropped", spi_request, 1'b0);
        @(negedge clk);
        check("p1_ready_after_done", req_ready, 1'b1);
        check("p1_latency", 64'(done_cyc - req_cyc), 64'd262);
        expect_frame(64'h06, 8);
        expect_frame(64'h02100004AABBCCDD, 64);
        expect_frame(64'h0500, 16);
        expect_frame(64'h0500, 16);
        expect_frame(64'h0500, 16);
        check_frames("p1");
        reject("low_addr", 1'b0, 24'h0FFFFC);

        // Single poll: minimum grant-to-done latency.
        clear_log();
        wip_q.push_back(1'b0);
        send(1'b0, 24'h100008, 32'h04030201);
        wait_done("p2");
        check("p2_error", error, 1'b0);
        repeat (2) @(negedge clk);
        check("p2_latency", 64'(done_cyc - req_cyc), 64'd188);
        expect_frame(64'h06, 8);
        expect_frame(64'h0210000801020304, 64);
        expect_frame(64'h0500, 16);
        check_frames("p2");

        reject("misaligned", 1'b0, 24'h100002);

`ifdef FLASH_WRITER_ERASE_EN
        clear_log();
        wip_q.push_back(1'b0);
        send(1'b1, 24'h123000, 32'h0);
        wait_done("erase");
        check("erase_error", error, 1'b0);
        repeat (2) @(negedge clk);
        expect_frame(64'h06, 8);
        expect_frame(64'h20123000, 32);
        expect_frame(64'h0500, 16);
        check_frames("erase");
`else
        reject("erase_off", 1'b1, 24'h123000);
`endif

        // WIP stuck high: poll limit of 3 ends with an error.
        clear_log();
        wip_default = 1'b1;
        send(1'b0, 24'h1FFFF0, 32'h0);
        wait_done("stuck");
        check("stuck_error", error, 1'b1);
        repeat (2) @(negedge clk);
        expect_frame(64'h06, 8);
        expect_frame(64'h021FFFF000000000, 64);
        expect_frame(64'h0500, 16);
        expect_frame(64'h0500, 16);
        expect_frame(64'h0500, 16);
        check_frames("stuck");
        wip_default = 1'b0;

        // Grant withdrawn during the data bytes.
        clear_log();
        send(1'b0, 24'h100020, 32'h12345678);
        for (int i = 0; i < 1000 && !(mon_opc == 8'h02 && mon_nbits >= 40 && !flash_csn); i++)
            @(negedge clk);
        check("gl_in_data", (mon_opc == 8'h02 && mon_nbits >= 40), 1'b1);
        grant_en = 1'b0;
        @(negedge clk);
        check("gl_csn", flash_csn, 1'b1);
        check("gl_done", done, 1'b1);
        check("gl_error", error, 1'b1);
        check("gl_request", spi_request, 1'b0);
        grant_en = 1'b1;
        @(negedge clk);
        check("gl_ready", req_ready, 1'b1);

        // Reset in the middle of a program frame.
        clear_log();
        send(1'b0, 24'h100040, 32'hCAFEF00D);
        for (int i = 0; i < 1000 && !(mon_opc == 8'h02 && mon_nbits >= 10 && !flash_csn); i++)
            @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_csn", flash_csn, 1'b1);
        check("mid_rst_sck", flash_sck, 1'b0);
        check("mid_rst_ready", req_ready, 1'b1);
        check("mid_rst_request", spi_request, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
